if_fetch: RTL and testbench

- Instruction-fetch stage of the LEGv8 core; the producer of the `inst` word consumed by ID.
- Holds the PC and issues one-at-a-time requests to a variable-latency instruction memory.
- Registers each returned word with its PC and a valid flag, and holds it while ID stalls.
- Accepts branch redirects from EX/MEM, discarding any in-flight fetch.

---
 rtl/if_fetch.sv | 130 +++++++++++++
 tb/tb_if_fetch.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// LEGv8 instruction-fetch stage: one outstanding request to a variable-latency imem,
// registered output with a one-entry skid buffer, and redirect flush of in-flight fetches.
module if_fetch #(
  parameter int unsigned        ADDR_W   = 64,
  parameter int unsigned        INST_W   = 32,
  parameter logic [ADDR_W-1:0]  PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StDrain} state_e;

  state_e            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] skid_pc;
  logic [INST_W-1:0] skid_inst;
  logic              skid_valid;

  logic              out_free;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] redir_pc;

  assign out_free = !inst_valid || !stall;
  assign pc_inc   = pc + ADDR_W'(4);
  assign redir_pc = redirect_pc & ~ADDR_W'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      pc         <= PC_RESET;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      skid_pc    <= '0;
      skid_inst  <= '0;
      skid_valid <= 1'b0;
    end else begin
      imem_req <= 1'b0;
      // Consumed with nothing to replace it; overridden below when a new word lands.
      if (inst_valid && !stall) begin
        inst_valid <= 1'b0;
        inst       <= '0;
      end
      if (redirect && state != StIdle) begin
        pc         <= redir_pc;
        inst_valid <= 1'b0;
        inst       <= '0;
        skid_valid <= 1'b0;
        case (state)
          StReq: state <= StDrain;
          StWait, StDrain: begin
            if (imem_rvalid) begin
              state     <= StReq;
              imem_req  <= 1'b1;
              imem_addr <= redir_pc;
            end else begin
              state <= StDrain;
            end
          end
          default: begin
            state     <= StReq;
            imem_req  <= 1'b1;
            imem_addr <= redir_pc;
          end
        endcase
      end else begin
        unique case (state)
          StIdle: begin
            state     <= StReq;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
          StReq: state <= StWait;
          StWait: begin
            if (imem_rvalid) begin
              if (out_free) begin
                inst       <= imem_rdata;
                inst_pc    <= pc;
                inst_valid <= 1'b1;
                pc         <= pc_inc;
                state      <= StReq;
                imem_req   <= 1'b1;
                imem_addr  <= pc_inc;
              end else begin
                skid_inst  <= imem_rdata;
                skid_pc    <= pc;
                skid_valid <= 1'b1;
                state      <= StHold;
              end
            end
          end
          StHold: begin
            if (!stall) begin
              inst       <= skid_inst;
              inst_pc    <= skid_pc;
              inst_valid <= skid_valid;
              skid_valid <= 1'b0;
              pc         <= pc_inc;
              state      <= StReq;
              imem_req   <= 1'b1;
              imem_addr  <= pc_inc;
            end
          end
          StDrain: begin
            if (imem_rvalid) begin
              state     <= StReq;
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: imem model with configurable latency, a scoreboard of expected
// (pc, word) pairs reseeded on reset/redirect, and directed plus randomized phases.
module tb_if_fetch;
  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned INST_W   = 32;
  localparam logic [63:0] PC_RESET = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_valid;

  int errors = 0;
  int checks = 0;
  int consumed = 0;

  // memory model controls
  int          lat_fix  = 1;
  bit          lat_rand = 1'b0;
  bit          stray    = 1'b0;
  bit          pend     = 1'b0;
  logic [63:0] pend_addr;
  int          pend_cnt;

  always #5 clk = ~clk;

  if_fetch #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .PC_RESET (PC_RESET)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:  return 32'hF844_02C9;
      64'h4:  return 32'h8B09_026A;
      64'h8:  return 32'hCB0A_028B;
      64'h40: return 32'h1400_0040;
      default: return a[31:0] ^ 32'hA5C3_0F00;
    endcase
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memory: one response per request after the chosen latency.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        check64("one_outstanding", 64'(pend), 64'h0);
        pend      = 1'b1;
        pend_addr = imem_addr;
        pend_cnt  = lat_rand ? int'($urandom_range(1, 4)) : lat_fix;
      end
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (!rst_n) pend = 1'b0;
      if (stray) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        stray       = 1'b0;
      end else if (pend) begin
        if (pend_cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pend        = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
    end
  end

  // Scoreboard: reset/redirect reseed the expected sequential stream; each consume pops one.
  logic [63:0] exp_q[$];
  logic [63:0] next_pc;
  int          idle;
  initial begin
    logic [63:0] e;
    next_pc = PC_RESET;
    idle    = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || redirect) begin
        exp_q.delete();
        next_pc = !rst_n ? PC_RESET : (redirect_pc & ~64'h3);
        idle    = 0;
      end
      while (exp_q.size() < 4) begin
        exp_q.push_back(next_pc);
        next_pc = next_pc + 64'd4;
      end
      if (rst_n && !redirect && inst_valid && !stall) begin
        e = exp_q.pop_front();
        check64("inst_pc", inst_pc, e);
        check64("inst", 64'(inst), 64'(mem_word(e)));
        consumed++;
        idle = 0;
      end else if (!rst_n || redirect || stall) begin
        idle = 0;
      end else begin
        idle++;
        if (idle > 40) begin
          checks++;
          errors++;
          $display("FAIL progress: no instruction delivered for %0d cycles", idle);
          idle = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // First request from now on must carry exp_addr.
  task automatic wait_req(input string name, input logic [63:0] exp_addr);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!imem_req && n < 30);
    if (!imem_req) begin
      checks++;
      errors++;
      $display("FAIL %s: no imem_req within 30 cycles, wanted addr %h", name, exp_addr);
    end else begin
      check64(name, imem_addr, exp_addr);
    end
  endtask

  // Skip ahead to the request for exp_addr.
  task automatic seek_req(input string name, input logic [63:0] exp_addr);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(imem_req && imem_addr == exp_addr) && n < 40);
    if (!(imem_req && imem_addr == exp_addr)) begin
      checks++;
      errors++;
      $display("FAIL %s: request for %h not seen within 40 cycles", name, exp_addr);
    end
  endtask

  initial begin
    int          vcount;
    int          n;
    logic [63:0] a1;
    logic [63:0] a2;
    rst_n       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check64("rst_req", 64'(imem_req), 64'h0);
    check64("rst_addr", imem_addr, 64'h0);
    check64("rst_inst", 64'(inst), 64'h0);
    check64("rst_inst_pc", inst_pc, 64'h0);
    check64("rst_valid", 64'(inst_valid), 64'h0);

    // Basic fetch at 1-cycle latency
    lat_fix = 1;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check64("req_first_cycle", 64'(imem_req), 64'h0);
    @(negedge clk);
    check64("req_second_cycle", 64'(imem_req), 64'h1);
    check64("basic_addr0", imem_addr, PC_RESET);
    vcount = 0;
    a1 = '1;
    a2 = '1;
    n  = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (inst_valid) vcount++;
      if (imem_req) begin
        if (n == 0) a1 = imem_addr;
        if (n == 1) a2 = imem_addr;
        n++;
      end
    end
    check64("basic_addr1", a1, 64'h4);
    check64("basic_addr2", a2, 64'h8);
    check64("basic_valid_duty", 64'(vcount), 64'd3);

    // Stall with skid capture
    do_reset();
    wait_req("stall_addr0", 64'h0);
    tick();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check64("stall_hold_inst", 64'(inst), 64'hF844_02C9);
      check64("stall_hold_pc", inst_pc, 64'h0);
      check64("stall_hold_valid", 64'(inst_valid), 64'h1);
      if (i > 0) check64("stall_no_req", 64'(imem_req), 64'h0);
    end
    tick();
    stall = 1'b0;
    @(negedge clk);
    check64("stall_release_no_req", 64'(imem_req), 64'h0);
    @(negedge clk);
    check64("skid_inst", 64'(inst), 64'h8B09_026A);
    check64("skid_pc", inst_pc, 64'h4);
    check64("skid_valid", 64'(inst_valid), 64'h1);
    check64("resume_req", 64'(imem_req), 64'h1);
    check64("resume_addr", imem_addr, 64'h8);

    // Redirect during WAIT at 3-cycle latency
    lat_fix = 3;
    do_reset();
    seek_req("redir_seek4", 64'h4);
    tick();
    redirect    = 1'b1;
    redirect_pc = 64'h40;
    tick();
    redirect = 1'b0;
    wait_req("redir_addr", 64'h40);
    tick();
    stall = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!inst_valid && n < 20);
    check64("redir_inst", 64'(inst), 64'h1400_0040);
    check64("redir_inst_pc", inst_pc, 64'h40);

    // Misaligned redirect while stalled with a valid output
    tick();
    redirect    = 1'b1;
    redirect_pc = 64'h103;
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    @(negedge clk);
    check64("misalign_valid", 64'(inst_valid), 64'h0);
    check64("misalign_inst", 64'(inst), 64'h0);
    wait_req("misalign_addr", 64'h100);

    // PC wrap
    lat_fix = 1;
    tick();
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect = 1'b0;
    wait_req("wrap_addr_top", 64'hFFFF_FFFF_FFFF_FFFC);
    wait_req("wrap_addr_zero", 64'h0);

    // Reset in WAIT, stray response right after release
    tick();
    lat_fix = 3;
    wait_req("pre_reset_addr", 64'h4);
    tick();
    rst_n = 1'b0;
    #1;
    check64("mid_rst_req", 64'(imem_req), 64'h0);
    check64("mid_rst_addr", imem_addr, 64'h0);
    check64("mid_rst_inst", 64'(inst), 64'h0);
    check64("mid_rst_inst_pc", inst_pc, 64'h0);
    check64("mid_rst_valid", 64'(inst_valid), 64'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    stray = 1'b1;
    wait_req("post_rst_addr", PC_RESET);
    @(negedge clk);
    check64("post_rst_stray_ignored", 64'(inst_valid), 64'h0);

    // Randomized traffic: random latency, stalls and redirects
    lat_rand = 1'b1;
    n = consumed;
    for (int i = 0; i < 1500; i++) begin
      tick();
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                                 : 64'($urandom_range(0, 1023));
    end
    tick();
    stall    = 1'b0;
    redirect = 1'b0;
    repeat (20) tick();
    check64("random_progress", 64'((consumed - n) > 150), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
